// File: rtl/alt_mem_ddrx_wdata_consume_ctrl_pkg.sv
// Shared defaults and helpers for the write-data consume controller.
// Covers the configuration widths, error-flag layout and pointer-width helper.
package alt_mem_ddrx_wdata_consume_ctrl_pkg;

  localparam int CFG_BURSTCOUNT_TRACKING_WIDTH_DEF = 7;
  localparam int CFG_BUFFER_ADDR_WIDTH_DEF         = 6;
  localparam int CFG_INT_SIZE_WIDTH_DEF            = 4;
  localparam int CFG_CMD_FIFO_DEPTH_DEF            = 8;

  localparam int ERR_W         = 1;
  localparam int ERR_ZERO_SIZE = 0;

  function automatic int ptr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alt_mem_ddrx_wdata_consume_ctrl_if.sv
// Command intake, tracker feedback and write-data ID bundle of the consume controller.
interface alt_mem_ddrx_wdata_consume_ctrl_if
  import alt_mem_ddrx_wdata_consume_ctrl_pkg::*;
#(
  parameter int CFG_BURSTCOUNT_TRACKING_WIDTH = CFG_BURSTCOUNT_TRACKING_WIDTH_DEF,
  parameter int CFG_BUFFER_ADDR_WIDTH         = CFG_BUFFER_ADDR_WIDTH_DEF,
  parameter int CFG_INT_SIZE_WIDTH            = CFG_INT_SIZE_WIDTH_DEF
);

  logic                                     cmd_valid;
  logic                                     cmd_ready;
  logic [CFG_INT_SIZE_WIDTH-1:0]            cmd_size;
  logic [CFG_BURSTCOUNT_TRACKING_WIDTH-1:0] burst_pending_burstcount;
  logic                                     burst_consumed_valid;
  logic [CFG_INT_SIZE_WIDTH-1:0]            burst_counsumed_burstcount;
  logic                                     wdata_id_valid;
  logic                                     wdata_id_ready;
  logic [CFG_BUFFER_ADDR_WIDTH-1:0]         wdata_id_addr;
  logic [CFG_INT_SIZE_WIDTH-1:0]            wdata_id_size;
  logic                                     err_zero_size;

  modport slave (
    input  cmd_valid, cmd_size, burst_pending_burstcount, wdata_id_ready,
    output cmd_ready, burst_consumed_valid, burst_counsumed_burstcount,
           wdata_id_valid, wdata_id_addr, wdata_id_size, err_zero_size
  );

  modport master (
    output cmd_valid, cmd_size, burst_pending_burstcount, wdata_id_ready,
    input  cmd_ready, burst_consumed_valid, burst_counsumed_burstcount,
           wdata_id_valid, wdata_id_addr, wdata_id_size, err_zero_size
  );

endinterface

// File: rtl/alt_mem_ddrx_cmd_size_fifo.sv
// Synchronous command-size FIFO with a registered head; a pushed entry is
// visible at the head no earlier than the cycle after the push.
module alt_mem_ddrx_cmd_size_fifo
  import alt_mem_ddrx_wdata_consume_ctrl_pkg::*;
#(
  parameter int WIDTH = CFG_INT_SIZE_WIDTH_DEF,
  parameter int DEPTH = CFG_CMD_FIFO_DEPTH_DEF
) (
  input  logic             ctl_clk,
  input  logic             ctl_reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  // Head tracks the entry at the post-update read pointer, taking the incoming
  // word when that slot is the one being written this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    head_d   = head_q;
    if (count_d != '0) begin
      if (push_i && (wr_ptr_q == rd_ptr_d)) head_d = data_i;
      else                                  head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge ctl_clk) begin
    if (!ctl_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge ctl_clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
    head_q <= head_d;
  end

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  a_no_push_full:  assert property (@(posedge ctl_clk) disable iff (!ctl_reset_n) push_i |-> !full_o);
  a_no_pop_empty:  assert property (@(posedge ctl_clk) disable iff (!ctl_reset_n) pop_i |-> !empty_o);

endmodule

// File: rtl/alt_mem_ddrx_wdata_consume_ctrl.sv
// Queues write-command sizes, consumes the head once the tracker holds enough
// beats, and issues buffer start address/size IDs on a registered valid/ready stage.
module alt_mem_ddrx_wdata_consume_ctrl
  import alt_mem_ddrx_wdata_consume_ctrl_pkg::*;
#(
  parameter int CFG_BURSTCOUNT_TRACKING_WIDTH = CFG_BURSTCOUNT_TRACKING_WIDTH_DEF,
  parameter int CFG_BUFFER_ADDR_WIDTH         = CFG_BUFFER_ADDR_WIDTH_DEF,
  parameter int CFG_INT_SIZE_WIDTH            = CFG_INT_SIZE_WIDTH_DEF,
  parameter int CFG_CMD_FIFO_DEPTH            = CFG_CMD_FIFO_DEPTH_DEF
) (
  input logic                              ctl_clk,
  input logic                              ctl_reset_n,
  alt_mem_ddrx_wdata_consume_ctrl_if.slave bus_if
);

  localparam int BTW   = CFG_BURSTCOUNT_TRACKING_WIDTH;
  localparam int BAW   = CFG_BUFFER_ADDR_WIDTH;
  localparam int INTW  = CFG_INT_SIZE_WIDTH;
  localparam int CMP_W = max_w(BTW, INTW);

  logic            fifo_full, fifo_empty;
  logic [INTW-1:0] head_size;
  logic            cmd_ready, accept, size_is_zero, push, pending_ok, consume;

  logic            rdy_en_q;
  logic [BAW-1:0]  wr_addr_q, wr_addr_d;
  logic            id_valid_q, id_valid_d;
  logic [BAW-1:0]  id_addr_q, id_addr_d;
  logic [INTW-1:0] id_size_q, id_size_d;
  logic [ERR_W-1:0] err_q, err_d;

  function automatic logic [BAW-1:0] addr_advance(input logic [BAW-1:0] base,
                                                  input logic [INTW-1:0] beats);
    return base + BAW'(beats);
  endfunction

  // Ready is held low through reset and never relaxed by a same-cycle pop.
  assign cmd_ready    = rdy_en_q & ~fifo_full;
  assign accept       = bus_if.cmd_valid & cmd_ready;
  assign size_is_zero = (bus_if.cmd_size == '0);
  assign push         = accept & ~size_is_zero;

  assign pending_ok = CMP_W'(bus_if.burst_pending_burstcount) >= CMP_W'(head_size);
  assign consume    = ~fifo_empty & pending_ok & (~id_valid_q | bus_if.wdata_id_ready);

  alt_mem_ddrx_cmd_size_fifo #(
    .WIDTH (INTW),
    .DEPTH (CFG_CMD_FIFO_DEPTH)
  ) u_cmd_size_fifo (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .push_i      (push),
    .data_i      (bus_if.cmd_size),
    .pop_i       (consume),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_size)
  );

  always_comb begin
    wr_addr_d  = wr_addr_q;
    id_valid_d = id_valid_q;
    id_addr_d  = id_addr_q;
    id_size_d  = id_size_q;
    err_d      = err_q;
    if (consume) begin
      wr_addr_d  = addr_advance(wr_addr_q, head_size);
      id_valid_d = 1'b1;
      id_addr_d  = wr_addr_q;
      id_size_d  = head_size;
    end else if (bus_if.wdata_id_ready) begin
      id_valid_d = 1'b0;
    end
    if (accept && size_is_zero) err_d[ERR_ZERO_SIZE] = 1'b1;
  end

  always_ff @(posedge ctl_clk) begin
    if (!ctl_reset_n) begin
      rdy_en_q   <= 1'b0;
      wr_addr_q  <= '0;
      id_valid_q <= 1'b0;
      id_addr_q  <= '0;
      id_size_q  <= '0;
      err_q      <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      wr_addr_q  <= wr_addr_d;
      id_valid_q <= id_valid_d;
      id_addr_q  <= id_addr_d;
      id_size_q  <= id_size_d;
      err_q      <= err_d;
    end
  end

  assign bus_if.cmd_ready                  = cmd_ready;
  assign bus_if.burst_consumed_valid       = consume;
  assign bus_if.burst_counsumed_burstcount = consume ? head_size : '0;
  assign bus_if.wdata_id_valid             = id_valid_q;
  assign bus_if.wdata_id_addr              = id_addr_q;
  assign bus_if.wdata_id_size              = id_size_q;
  assign bus_if.err_zero_size              = err_q[ERR_ZERO_SIZE];

  a_consume_has_data: assert property (@(posedge ctl_clk) disable iff (!ctl_reset_n)
    consume |-> (CMP_W'(bus_if.burst_pending_burstcount) >= CMP_W'(head_size)));
  a_cfg_widths: assert property (@(posedge ctl_clk) BTW > INTW);

endmodule

// File: tb/tb_alt_mem_ddrx_wdata_consume_ctrl.sv
// Directed bench for the write-data consume controller.
module tb_alt_mem_ddrx_wdata_consume_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alt_mem_ddrx_wdata_consume_ctrl_if #(
    .CFG_BURSTCOUNT_TRACKING_WIDTH (7),
    .CFG_BUFFER_ADDR_WIDTH         (6),
    .CFG_INT_SIZE_WIDTH            (4)
  ) bus ();

  alt_mem_ddrx_wdata_consume_ctrl #(
    .CFG_BURSTCOUNT_TRACKING_WIDTH (7),
    .CFG_BUFFER_ADDR_WIDTH         (6),
    .CFG_INT_SIZE_WIDTH            (4),
    .CFG_CMD_FIFO_DEPTH            (8)
  ) u_dut (
    .ctl_clk     (clk),
    .ctl_reset_n (rst_n),
    .bus_if      (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid                = 1'b0;
    bus.cmd_size                 = 4'd0;
    bus.burst_pending_burstcount = 7'd0;
    bus.wdata_id_ready           = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    settle();
    n_total++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %0d want 0", bus.cmd_ready); else n_pass++;
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL rst_consume got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    n_total++; if (bus.burst_counsumed_burstcount !== 4'd0) $display("FAIL rst_burstcount got %0d want 0", bus.burst_counsumed_burstcount); else n_pass++;
    n_total++; if (bus.wdata_id_valid !== 1'b0) $display("FAIL rst_id_valid got %0d want 0", bus.wdata_id_valid); else n_pass++;
    n_total++; if (bus.wdata_id_addr !== 6'd0) $display("FAIL rst_id_addr got %0d want 0", bus.wdata_id_addr); else n_pass++;
    n_total++; if (bus.wdata_id_size !== 4'd0) $display("FAIL rst_id_size got %0d want 0", bus.wdata_id_size); else n_pass++;
    n_total++; if (bus.err_zero_size !== 1'b0) $display("FAIL rst_err got %0d want 0", bus.err_zero_size); else n_pass++;
    rst_n = 1'b1;
    step();
    settle();
    n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_release_ready got %0d want 1", bus.cmd_ready); else n_pass++;
  endtask

  task automatic test_single_latency();
    do_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_size  = 4'd4;
    settle();
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_size  = 4'd0;
    settle();
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL single_wait1 consume got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    step();
    settle();
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL single_wait2 consume got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    step();
    bus.burst_pending_burstcount = 7'd4;
    settle();
    n_total++; if (bus.burst_consumed_valid !== 1'b1) $display("FAIL single_consume got %0d want 1", bus.burst_consumed_valid); else n_pass++;
    n_total++; if (bus.burst_counsumed_burstcount !== 4'd4) $display("FAIL single_burstcount got %0d want 4", bus.burst_counsumed_burstcount); else n_pass++;
    step();
    bus.burst_pending_burstcount = 7'd0;
    settle();
    n_total++; if (bus.wdata_id_valid !== 1'b1) $display("FAIL single_id_valid got %0d want 1", bus.wdata_id_valid); else n_pass++;
    n_total++; if (bus.wdata_id_addr !== 6'd0) $display("FAIL single_id_addr got %0d want 0", bus.wdata_id_addr); else n_pass++;
    n_total++; if (bus.wdata_id_size !== 4'd4) $display("FAIL single_id_size got %0d want 4", bus.wdata_id_size); else n_pass++;
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL single_no_reconsume got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    step();
    settle();
    n_total++; if (bus.wdata_id_valid !== 1'b0) $display("FAIL single_id_drop got %0d want 0", bus.wdata_id_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int consumed_before;
    logic exp_cons, exp_idv;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      consumed_before = (k < 1) ? 0 : ((k > 5) ? 4 : k - 1);
      if (consumed_before > 4) consumed_before = 4;
      bus.burst_pending_burstcount = 7'(16 - 4 * consumed_before);
      bus.cmd_valid = (k < 4);
      bus.cmd_size  = 4'd4;
      settle();
      exp_cons = (k >= 1) && (k <= 4);
      exp_idv  = (k >= 2) && (k <= 5);
      n_total++; if (bus.burst_consumed_valid !== exp_cons) $display("FAIL b2b_consume k=%0d got %0d want %0d", k, bus.burst_consumed_valid, exp_cons); else n_pass++;
      n_total++; if (bus.burst_counsumed_burstcount !== (exp_cons ? 4'd4 : 4'd0)) $display("FAIL b2b_burstcount k=%0d got %0d want %0d", k, bus.burst_counsumed_burstcount, exp_cons ? 4 : 0); else n_pass++;
      n_total++; if (bus.wdata_id_valid !== exp_idv) $display("FAIL b2b_id_valid k=%0d got %0d want %0d", k, bus.wdata_id_valid, exp_idv); else n_pass++;
      if (exp_idv) begin
        n_total++; if (bus.wdata_id_addr !== 6'(4 * (k - 2))) $display("FAIL b2b_id_addr k=%0d got %0d want %0d", k, bus.wdata_id_addr, 4 * (k - 2)); else n_pass++;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_addr_wrap();
    int sz  [6] = '{15, 15, 15, 15, 8, 4};
    int adr [6] = '{0, 15, 30, 45, 60, 4};
    do_reset();
    bus.burst_pending_burstcount = 7'd127;
    for (int k = 0; k < 8; k++) begin
      bus.cmd_valid = (k < 6);
      bus.cmd_size  = (k < 6) ? 4'(sz[k]) : 4'd0;
      settle();
      if (k >= 2) begin
        n_total++; if (bus.wdata_id_valid !== 1'b1) $display("FAIL wrap_id_valid k=%0d got %0d want 1", k, bus.wdata_id_valid); else n_pass++;
        n_total++; if (bus.wdata_id_addr !== 6'(adr[k-2])) $display("FAIL wrap_id_addr k=%0d got %0d want %0d", k, bus.wdata_id_addr, adr[k-2]); else n_pass++;
        n_total++; if (bus.wdata_id_size !== 4'(sz[k-2])) $display("FAIL wrap_id_size k=%0d got %0d want %0d", k, bus.wdata_id_size, sz[k-2]); else n_pass++;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic exp_cons;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      bus.cmd_valid                = (k <= 9);
      bus.cmd_size                 = (k < 8) ? 4'd2 : 4'd3;
      bus.burst_pending_burstcount = (k >= 8) ? 7'd127 : 7'd0;
      settle();
      exp_cons = (k >= 8) && (k <= 16);
      if (k <= 9) begin
        n_total++; if (bus.cmd_ready !== (k != 8)) $display("FAIL full_ready k=%0d got %0d want %0d", k, bus.cmd_ready, k != 8); else n_pass++;
      end
      n_total++; if (bus.burst_consumed_valid !== exp_cons) $display("FAIL full_consume k=%0d got %0d want %0d", k, bus.burst_consumed_valid, exp_cons); else n_pass++;
      if (k == 16) begin
        n_total++; if (bus.burst_counsumed_burstcount !== 4'd3) $display("FAIL full_ninth_size got %0d want 3", bus.burst_counsumed_burstcount); else n_pass++;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_id_stall();
    do_reset();
    bus.burst_pending_burstcount = 7'd127;
    bus.wdata_id_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_size  = 4'd5;
    settle();
    step();
    bus.cmd_size = 4'd6;
    settle();
    n_total++; if (bus.burst_consumed_valid !== 1'b1) $display("FAIL stall_first_consume got %0d want 1", bus.burst_consumed_valid); else n_pass++;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 2; k < 4; k++) begin
      settle();
      n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL stall_blocked k=%0d got %0d want 0", k, bus.burst_consumed_valid); else n_pass++;
      n_total++; if (bus.wdata_id_valid !== 1'b1) $display("FAIL stall_id_valid k=%0d got %0d want 1", k, bus.wdata_id_valid); else n_pass++;
      n_total++; if (bus.wdata_id_addr !== 6'd0) $display("FAIL stall_id_addr k=%0d got %0d want 0", k, bus.wdata_id_addr); else n_pass++;
      n_total++; if (bus.wdata_id_size !== 4'd5) $display("FAIL stall_id_size k=%0d got %0d want 5", k, bus.wdata_id_size); else n_pass++;
      step();
    end
    bus.wdata_id_ready = 1'b1;
    settle();
    n_total++; if (bus.burst_consumed_valid !== 1'b1) $display("FAIL stall_release_consume got %0d want 1", bus.burst_consumed_valid); else n_pass++;
    n_total++; if (bus.burst_counsumed_burstcount !== 4'd6) $display("FAIL stall_release_count got %0d want 6", bus.burst_counsumed_burstcount); else n_pass++;
    step();
    settle();
    n_total++; if (bus.wdata_id_valid !== 1'b1) $display("FAIL stall_reload_valid got %0d want 1", bus.wdata_id_valid); else n_pass++;
    n_total++; if (bus.wdata_id_addr !== 6'd5) $display("FAIL stall_reload_addr got %0d want 5", bus.wdata_id_addr); else n_pass++;
    n_total++; if (bus.wdata_id_size !== 4'd6) $display("FAIL stall_reload_size got %0d want 6", bus.wdata_id_size); else n_pass++;
    step();
    settle();
    n_total++; if (bus.wdata_id_valid !== 1'b0) $display("FAIL stall_drain got %0d want 0", bus.wdata_id_valid); else n_pass++;
  endtask

  task automatic test_zero_size_and_reset();
    do_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_size  = 4'd0;
    settle();
    step();
    bus.cmd_valid = 1'b0;
    bus.burst_pending_burstcount = 7'd127;
    settle();
    n_total++; if (bus.err_zero_size !== 1'b1) $display("FAIL zero_err got %0d want 1", bus.err_zero_size); else n_pass++;
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL zero_not_queued got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    step();
    bus.burst_pending_burstcount = 7'd0;
    for (int k = 0; k < 3; k++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_size  = 4'd7;
      settle();
      step();
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    step();
    settle();
    n_total++; if (bus.cmd_ready !== 1'b0) $display("FAIL midrst_ready got %0d want 0", bus.cmd_ready); else n_pass++;
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL midrst_consume got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    n_total++; if (bus.burst_counsumed_burstcount !== 4'd0) $display("FAIL midrst_count got %0d want 0", bus.burst_counsumed_burstcount); else n_pass++;
    n_total++; if (bus.wdata_id_valid !== 1'b0) $display("FAIL midrst_id_valid got %0d want 0", bus.wdata_id_valid); else n_pass++;
    n_total++; if (bus.err_zero_size !== 1'b0) $display("FAIL midrst_err got %0d want 0", bus.err_zero_size); else n_pass++;
    rst_n = 1'b1;
    bus.burst_pending_burstcount = 7'd127;
    step();
    settle();
    n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL postrst_ready got %0d want 1", bus.cmd_ready); else n_pass++;
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL postrst_consume1 got %0d want 0", bus.burst_consumed_valid); else n_pass++;
    step();
    settle();
    n_total++; if (bus.burst_consumed_valid !== 1'b0) $display("FAIL postrst_consume2 got %0d want 0", bus.burst_consumed_valid); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_addr_wrap();
    test_fifo_full();
    test_id_stall();
    test_zero_size_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
